md_sequencer: RTL and testbench

//   Multi-cycle multiply/divide unit with its own HI/LO registers, sitting beside the EX-stage ALU.

---
 rtl/md_sequencer.sv | 137 +++++++++++++
 tb/tb_md_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle multiply/divide unit with private HI/LO registers.
//
// The result of an operation is computed from the operands present at the
// start pulse and parked in a pending register. busy is then held for a
// fixed op-dependent number of cycles before the pending value is committed
// to HI/LO. mthi/mtlo write HI/LO on the next edge and never raise busy.
//
// Parameters:
//   MULT_CYCLES  busy duration for mult/multu (>=1)
//   DIV_CYCLES   busy duration for div/divu (>=1)
// Ports:
//   clk    clock; all state changes on its rising edge
//   reset  synchronous active-high reset; aborts any in-flight op
//   start  one-cycle issue strobe
//   MDop   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op
//   A, B   rs / rt operands
//   busy   registered; high while an operation is in flight
//   HI, LO architectural HI/LO registers
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   pend_hi_q, pend_lo_q;
  logic          pend_dz_q;

  // Result of the operation currently presented on MDop/A/B.
  logic [31:0] res_hi_d, res_lo_d;
  logic [63:0] prod_s, prod_u;
  logic        is_sdiv, neg_q, neg_r;
  logic [31:0] dvd, dvs, dvs_safe, q_mag, r_mag;

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed division goes through magnitudes so the quotient truncates toward
  // zero and 0x8000_0000 / -1 wraps to 0x8000_0000 with no overflow trap.
  assign is_sdiv  = (MDop == 3'd2);
  assign dvd      = (is_sdiv && A[31]) ? (~A + 32'd1) : A;
  assign dvs      = (is_sdiv && B[31]) ? (~B + 32'd1) : B;
  // A zero divisor never commits; substitute 1 so the divider stays defined.
  assign dvs_safe = (B == 32'd0) ? 32'd1 : dvs;
  assign q_mag    = dvd / dvs_safe;
  assign r_mag    = dvd % dvs_safe;
  assign neg_q    = is_sdiv && (A[31] ^ B[31]);
  assign neg_r    = is_sdiv && A[31];

  always_comb begin
    res_hi_d = 32'd0;
    res_lo_d = 32'd0;
    case (MDop)
      3'd0: begin
        res_hi_d = prod_s[63:32];
        res_lo_d = prod_s[31:0];
      end
      3'd1: begin
        res_hi_d = prod_u[63:32];
        res_lo_d = prod_u[31:0];
      end
      3'd2, 3'd3: begin
        res_hi_d = neg_r ? (~r_mag + 32'd1) : r_mag;
        res_lo_d = neg_q ? (~q_mag + 32'd1) : q_mag;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_dz_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            case (MDop)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                pend_hi_q <= res_hi_d;
                pend_lo_q <= res_lo_d;
                pend_dz_q <= MDop[1] && (B == 32'd0);
                cnt_q     <= MDop[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                busy_q    <= 1'b1;
                state_q   <= RUN;
              end
              3'd4:    hi_q <= A;
              3'd5:    lo_q <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          // start is deliberately not looked at here.
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            if (!pend_dz_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  MDop;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  int n_vec = 0;
  int n_err = 0;

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .MDop(MDop),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [31:0] pre_hi, pre_lo;
    logic [31:0] exp_hi, exp_lo;
    int          n;
  } vec_t;

  vec_t vecs[9];

  // Advance one edge; sample/drive 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; MDop = op; A = a; B = b;
    tick();
    start = 1'b0; MDop = 3'd7;
  endtask

  // mthi then mtlo on consecutive edges, checking each lands alone.
  task automatic preload(input logic [31:0] h, input logic [31:0] l);
    logic [31:0] old_lo;
    old_lo = LO;
    issue(3'd4, h, 32'd0);
    chk("mthi_hi", HI, h);
    chk("mthi_lo_untouched", LO, old_lo);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    issue(3'd5, l, 32'd0);
    chk("mtlo_lo", LO, l);
    chk("mtlo_hi_kept", HI, h);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // {op, a, b, pre_hi, pre_lo, exp_hi, exp_lo, cycles}
    vecs[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3,        32'hAAAA_0000, 32'hBBBB_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'd2,        32'h1,         32'h2,         32'h0000_0001, 32'hFFFF_FFFE, 5};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'h3,         32'h4,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{3'd3, 32'd7,         32'd0,        32'h11,        32'h22,        32'h0000_0011, 32'h0000_0022, 10};
    vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h5,        32'h6,         32'h0000_0000, 32'h8000_0000, 10};
    vecs[5] = '{3'd2, 32'd100,       32'hFFFF_FFF9, 32'h7,        32'h8,         32'h0000_0002, 32'hFFFF_FFF2, 10};
    vecs[6] = '{3'd3, 32'hFFFF_FFFF, 32'd10,       32'h9,         32'hA,         32'h0000_0005, 32'h1999_9999, 10};
    vecs[7] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'hB,        32'hC,         32'h4000_0000, 32'h0000_0000, 5};
    vecs[8] = '{3'd2, 32'd5,         32'd0,        32'h3333,      32'h4444,      32'h0000_3333, 32'h0000_4444, 10};

    reset = 1'b1; start = 1'b0; MDop = 3'd7; A = '0; B = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);

    // No-op codes are ignored.
    issue(3'd6, 32'hDEAD_BEEF, 32'd1);
    chk("noop6_hi", HI, 32'd0);
    chk("noop6_busy", {31'd0, busy}, 32'd0);
    issue(3'd7, 32'hDEAD_BEEF, 32'd1);
    chk("noop7_lo", LO, 32'd0);

    for (int i = 0; i < 9; i++) begin
      preload(vecs[i].pre_hi, vecs[i].pre_lo);
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      for (int k = 0; k < vecs[i].n; k++) begin
        chk($sformatf("v%0d_busy_c%0d", i, k), {31'd0, busy}, 32'd1);
        chk($sformatf("v%0d_hi_hold_c%0d", i, k), HI, vecs[i].pre_hi);
        chk($sformatf("v%0d_lo_hold_c%0d", i, k), LO, vecs[i].pre_lo);
        // Operand changes during RUN must not matter.
        A = $urandom; B = $urandom;
        tick();
      end
      chk($sformatf("v%0d_busy_end", i), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_hi", i), HI, vecs[i].exp_hi);
      chk($sformatf("v%0d_lo", i), LO, vecs[i].exp_lo);
      $display("vec %0d op=%0d a=%h b=%h -> HI=%h LO=%h", i, vecs[i].op, vecs[i].a, vecs[i].b, HI, LO);
    end

    // mthi/mtlo/new op while busy are ignored.
    preload(32'h1, 32'h2);
    issue(3'd1, 32'd6, 32'd7);
    tick();
    issue(3'd4, 32'hDEAD_0001, 32'd0);
    issue(3'd5, 32'hDEAD_0002, 32'd0);
    issue(3'd1, 32'd100, 32'd100);
    chk("runmt_hi_hold", HI, 32'h1);
    chk("runmt_busy", {31'd0, busy}, 32'd1);
    tick();  // edge E0+5
    chk("runmt_busy_end", {31'd0, busy}, 32'd0);
    chk("runmt_hi", HI, 32'd0);
    chk("runmt_lo", LO, 32'd42);
    $display("seq run-ignore -> HI=%h LO=%h", HI, LO);

    // Reset in the middle of a divide aborts it with no commit.
    preload(32'h55, 32'h66);
    issue(3'd3, 32'd100, 32'd3);
    tick(); tick(); tick();
    chk("abort_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    for (int k = 0; k < 10; k++) tick();
    chk("abort_no_late_hi", HI, 32'd0);
    chk("abort_no_late_lo", LO, 32'd0);
    chk("abort_no_late_busy", {31'd0, busy}, 32'd0);
    $display("seq reset-abort -> busy=%0d HI=%h LO=%h", busy, HI, LO);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
